// File: rtl/and_gate_bist_ctrl_if.sv
// Signal bundle between the AND-gate self-test sequencer and whatever
// drives it (a bench, a cosim harness or FPGA glue logic).
//
// Handshake: start and abort are single-cycle, level-sampled requests on
// the rising clock edge. There is no ready signal. start is taken only
// while busy is low, and abort is taken in every state. done is a
// one-cycle pulse with no acknowledge. pass, err_count and fail_* are
// status values that stay valid until the next start, abort or reset
// changes them.
interface and_gate_bist_ctrl_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             abort;
    logic             y_in;
    logic             a_out;
    logic             b_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             fail_valid;
    logic [1:0]       fail_vec;
    logic             fail_y;
    logic [1:0]       dbg_state;

    modport master (
        output start, abort, y_in,
        input  a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_vec, fail_y, dbg_state
    );

    modport slave (
        input  start, abort, y_in,
        output a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_vec, fail_y, dbg_state
    );
endinterface

// File: rtl/and_gate_bist_ctrl.sv
// Self-test sequencer for one external AND gate. It walks the gate
// inputs through 00, 01, 10, 11 and lets each vector settle. It then
// samples y against a&b, counts the mismatches, and records the first
// failing vector.
module and_gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1,
    parameter int STOP_ON_ERR   = 1,
    parameter int ERR_W         = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    and_gate_bist_ctrl_if.slave bus
);
    // Down-counter reload value. A settle time of 0 behaves like 1.
    localparam logic [7:0]       SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      LOOP_LAST   = (LOOPS <= 1) ? 16'd0 : 16'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      r_loop;
    logic [15:0]      w_loop_nxt;
    logic [7:0]       r_settle;
    logic             r_a;
    logic             r_b;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic [ERR_W-1:0] r_err;
    logic             r_fail_valid;
    logic [1:0]       r_fail_vec;
    logic             r_fail_y;
    logic             r_pass;
    logic             w_mismatch;
    logic             w_run_start;

    // The expected value for vector {a,b} is simply a&b.
    assign w_mismatch  = (bus.y_in != (r_idx[1] & r_idx[0]));
    assign w_run_start = (r_state == S_IDLE) && bus.start && !bus.abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. abort beats every other condition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run_start) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle == 8'd0) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_mismatch && (STOP_ON_ERR != 0)) begin
                    w_state_nxt = S_DONE;
                end else if ((r_idx != 2'd3) || (r_loop != LOOP_LAST)) begin
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: next vector/loop indices and the gate inputs to register.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_loop_nxt = r_loop;
        if (w_run_start) begin
            w_idx_nxt  = 2'd0;
            w_loop_nxt = 16'd0;
        end else if ((r_state == S_CHECK) && (w_state_nxt == S_DRIVE)) begin
            if (r_idx == 2'd3) begin
                w_idx_nxt  = 2'd0;
                w_loop_nxt = r_loop + 16'd1;
            end else begin
                w_idx_nxt = r_idx + 2'd1;
            end
        end
        // The gate inputs are held through DRIVE and CHECK and are low otherwise.
        if ((w_state_nxt == S_DRIVE) || (w_state_nxt == S_CHECK)) begin
            w_a_nxt = w_idx_nxt[1];
            w_b_nxt = w_idx_nxt[0];
        end else begin
            w_a_nxt = 1'b0;
            w_b_nxt = 1'b0;
        end
    end

    // Vector index, loop counter, settle counter and the registered gate inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= 2'd0;
            r_loop   <= 16'd0;
            r_settle <= 8'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_loop <= w_loop_nxt;
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            if ((w_state_nxt == S_DRIVE) && (r_state != S_DRIVE)) begin
                r_settle <= SETTLE_LAST;
            end else if ((r_state == S_DRIVE) && (r_settle != 8'd0)) begin
                r_settle <= r_settle - 8'd1;
            end
        end
    end

    // Result capture. A start clears the results, CHECK accumulates them,
    // DONE decides pass, and abort freezes everything except pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_y     <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_run_start) begin
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_y     <= 1'b0;
            r_pass       <= 1'b0;
        end else if (bus.abort) begin
            r_pass <= 1'b0;
        end else if (r_state == S_CHECK) begin
            if (w_mismatch) begin
                if (r_err != ERR_MAX) begin
                    r_err <= r_err + 1'b1;
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_vec   <= r_idx;
                    r_fail_y     <= bus.y_in;
                end
            end
        end else if (r_state == S_DONE) begin
            r_pass <= (r_err == '0);
        end
    end

    assign bus.a_out      = r_a;
    assign bus.b_out      = r_b;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;
    assign bus.fail_y     = r_fail_y;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_and_gate_bist_ctrl.sv
// Bench for and_gate_bist_ctrl. Three differently configured sequencers
// share start/abort/reset. Each one tests its own copy of a gate whose
// behaviour is a 4-entry truth table. A sweep-level model predicts the
// per-cycle activity and the final results of each instance.
module tb_and_gate_bist_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] tt;  // gate output indexed by {a,b}

    int checks = 0;
    int errors = 0;

    // Instance setup: settle (0 on u2 behaves as 1), loops, stop flag, counter max.
    int p_settle [3] = '{1, 3, 1};
    int p_loops  [3] = '{1, 3, 4};
    int p_stop   [3] = '{1, 0, 0};
    int p_errmax [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    and_gate_bist_ctrl_if #(.ERR_W(8)) if0 ();
    and_gate_bist_ctrl_if #(.ERR_W(8)) if1 ();
    and_gate_bist_ctrl_if #(.ERR_W(2)) if2 ();

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;
    assign if0.abort = abort;
    assign if1.abort = abort;
    assign if2.abort = abort;
    assign if0.y_in  = tt[{if0.a_out, if0.b_out}];
    assign if1.y_in  = tt[{if1.a_out, if1.b_out}];
    assign if2.y_in  = tt[{if2.a_out, if2.b_out}];

    and_gate_bist_ctrl #(.SETTLE_CYCLES(1), .LOOPS(1), .STOP_ON_ERR(1), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    and_gate_bist_ctrl #(.SETTLE_CYCLES(3), .LOOPS(3), .STOP_ON_ERR(0), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    and_gate_bist_ctrl #(.SETTLE_CYCLES(0), .LOOPS(4), .STOP_ON_ERR(0), .ERR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    logic [3:0] obs_ctl  [3];  // {busy, done, a, b}
    logic [7:0] obs_err  [3];
    logic [3:0] obs_fail [3];  // {fail_valid, fail_vec, fail_y}
    logic       obs_pass [3];

    assign obs_ctl[0]  = {if0.busy, if0.done, if0.a_out, if0.b_out};
    assign obs_ctl[1]  = {if1.busy, if1.done, if1.a_out, if1.b_out};
    assign obs_ctl[2]  = {if2.busy, if2.done, if2.a_out, if2.b_out};
    assign obs_err[0]  = if0.err_count;
    assign obs_err[1]  = if1.err_count;
    assign obs_err[2]  = {6'd0, if2.err_count};
    assign obs_fail[0] = {if0.fail_valid, if0.fail_vec, if0.fail_y};
    assign obs_fail[1] = {if1.fail_valid, if1.fail_vec, if1.fail_y};
    assign obs_fail[2] = {if2.fail_valid, if2.fail_vec, if2.fail_y};
    assign obs_pass[0] = if0.pass;
    assign obs_pass[1] = if1.pass;
    assign obs_pass[2] = if2.pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sweep-level result model: walk the vector list, count mismatches and
    // note where a stop-on-error run ends.
    task automatic model(input logic [3:0] t, input int i, output int exec,
                         output int err, output logic [3:0] fail, output logic pass);
        int   mism    = 0;
        logic stopped = 1'b0;
        logic want;
        exec = 0;
        fail = 4'd0;
        for (int l = 0; l < p_loops[i]; l++) begin
            for (int v = 0; v < 4; v++) begin
                if (!stopped) begin
                    exec++;
                    want = (v == 3);
                    if (t[v] !== want) begin
                        mism++;
                        if (!fail[3]) fail = {1'b1, 2'(v), t[v]};
                        if (p_stop[i] != 0) stopped = 1'b1;
                    end
                end
            end
        end
        err  = (mism > p_errmax[i]) ? p_errmax[i] : mism;
        pass = (mism == 0);
    endtask

    // Expected {busy, done, a, b} k cycles after the edge that takes start.
    function automatic logic [3:0] exp_ctl(input int i, input int k, input int exec, input int abort_k);
        int per = p_settle[i] + 1;
        int p;
        if ((abort_k > 0) && (k > abort_k)) return 4'b0000;
        if (k <= exec * per) begin
            p = (k - 1) / per;
            return {2'b10, 2'(p % 4)};
        end
        if (k == exec * per + 1) return 4'b1100;
        return 4'b0000;
    endfunction

    // One run: pulse start, optionally re-pulse start or abort at cycle k,
    // then check every cycle and the final results. Aborts are only
    // requested with fault-free tables.
    task automatic run(input logic [3:0] t, input int repulse_k, input int abort_k);
        int         exec_n   [3];
        int         exp_err  [3];
        logic [3:0] exp_fail [3];
        logic       exp_pass [3];
        int         end_k    [3];
        int         kmax = 0;
        tt = t;
        for (int i = 0; i < 3; i++) begin
            model(t, i, exec_n[i], exp_err[i], exp_fail[i], exp_pass[i]);
            if (abort_k > 0) begin
                end_k[i]    = abort_k + 1;
                exp_pass[i] = 1'b0;
            end else begin
                end_k[i] = exec_n[i] * (p_settle[i] + 1) + 2;
            end
            if (end_k[i] > kmax) kmax = end_k[i];
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= kmax; k++) begin
            start = (k == repulse_k);
            abort = (k == abort_k);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("ctl t%h u%0d k%0d", t, i, k), 32'(obs_ctl[i]),
                      32'(exp_ctl(i, k, exec_n[i], abort_k)));
                if (k == end_k[i]) begin
                    check($sformatf("err t%h u%0d", t, i), 32'(obs_err[i]), 32'(exp_err[i]));
                    check($sformatf("fail t%h u%0d", t, i), 32'(obs_fail[i]), 32'(exp_fail[i]));
                    check($sformatf("pass t%h u%0d", t, i), 32'(obs_pass[i]), 32'(exp_pass[i]));
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tt    = 4'b1000;
        #1;
        // Asynchronous reset values, before any clock edge.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst ctl u%0d", i), 32'(obs_ctl[i]), 32'd0);
            check($sformatf("rst err u%0d", i), 32'(obs_err[i]), 32'd0);
            check($sformatf("rst fail u%0d", i), 32'(obs_fail[i]), 32'd0);
            check($sformatf("rst pass u%0d", i), 32'(obs_pass[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed truth tables: good gate, stuck-at-1, OR, stuck-at-0.
        run(4'b1000, 0, 0);
        run(4'b1111, 0, 0);
        run(4'b1110, 0, 0);
        run(4'b0000, 0, 0);

        // A start re-pulsed mid-run must not disturb the timing.
        run(4'b1000, 2, 0);

        // Abort during the third vector's DRIVE, then a clean run.
        run(4'b1000, 0, 5);
        run(4'b1000, 0, 0);

        // start and abort together in IDLE: no run, and pass is cleared.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("start+abort ctl u%0d k%0d", i, k), 32'(obs_ctl[i]), 32'd0);
                check($sformatf("start+abort pass u%0d k%0d", i, k), 32'(obs_pass[i]), 32'd0);
            end
            @(negedge clk);
        end

        // Random gate behaviours, with an occasional start re-pulse.
        for (int r = 0; r < 8; r++) begin
            run(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0);
        end

        // Reset in the middle of u2's third CHECK, with errors already counted.
        tt = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst ctl u%0d", i), 32'(obs_ctl[i]), 32'd0);
            check($sformatf("midrst err u%0d", i), 32'(obs_err[i]), 32'd0);
            check($sformatf("midrst fail u%0d", i), 32'(obs_fail[i]), 32'd0);
            check($sformatf("midrst pass u%0d", i), 32'(obs_pass[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/and_gate_bist_ctrl.md
Name: and_gate_bist_ctrl

Overview:
- Synthesizable self-test sequencer for one external `and_gate` instance.
- Drives the gate's a/b inputs through the full truth table in the order 00, 01, 10, 11, waits a settle interval, and samples y against the expected a&b.
- Accumulates errors and captures the first failing vector.
- Provides the in-hardware equivalent of the directed checks used in simulation, so the same gate can be exercised on cosim and FPGA targets.

Parameters:
- SETTLE_CYCLES, 1, cycles a/b are held before y is sampled (legal 1..255; 0 is treated as 1)
- LOOPS, 1, number of full 4-vector sweeps per run (legal 1..65535)
- STOP_ON_ERR, 1, 1 = end run at first mismatch; 0 = complete all sweeps
- ERR_W, 8, width of the error counter

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request; honoured only in IDLE
- abort  in  1  synchronous cancel; honoured in any state
- y_in  in  1  output of the gate under test
- a_out  out  1  drives gate input a (registered)
- b_out  out  1  drives gate input b (registered)
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at the end of a completed run
- pass  out  1  high after a completed run with zero errors; held until the next start, abort or reset
- err_count  out  ERR_W  mismatches in the current/last run; saturates at all-ones
- fail_valid  out  1  a first failure has been captured
- fail_vec  out  2  {a,b} of the first failing vector
- fail_y  out  1  y_in value observed at the first failure

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; vector index=0; loop counter=0; all outputs 0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - a_out=b_out=0, busy=0.
  - start=1 (with abort=0): clear err_count, fail_valid, fail_vec, fail_y and pass; set index=0, loop=0; go to DRIVE.
- DRIVE:
  - a_out=index[1], b_out=index[0], registered on entry.
  - Held for exactly SETTLE_CYCLES cycles, then go to CHECK.
  - busy=1 from the first DRIVE cycle until DONE exits.
- CHECK (one cycle): a/b are still held; expected = index[1]&index[0]; compare with y_in.
  - On mismatch: err_count increments, saturating at all-ones.
  - On the first mismatch of a run: fail_valid=1, fail_vec=index, fail_y=y_in. Later mismatches do not overwrite these.
  - Next state:
    - mismatch and STOP_ON_ERR=1 → DONE
    - else index<3 → index+1, DRIVE
    - else index=3 and loop<LOOPS-1 → index=0, loop+1, DRIVE
    - else → DONE
- DONE (one cycle):
  - done=1; a_out=b_out=0.
  - pass=1 iff err_count==0 (captured into the pass register).
  - Then go to IDLE.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - A clean run asserts done LOOPS*4*(SETTLE_CYCLES+1) cycles after the edge that samples start.
  - An early stop asserts done in the cycle after the failing CHECK.
- start while busy (DRIVE/CHECK/DONE): ignored, with no restart and no side effects.
- abort=1 in any non-IDLE state:
  - Next state IDLE; a_out=b_out=0, busy=0, pass=0.
  - No done pulse.
  - err_count and fail_* retain their values.
- abort in IDLE: clears pass only.
- start and abort in the same cycle: abort wins; the run does not begin.
- Reset mid-run: immediate return to reset values. No done, no pass.
- y_in is sampled only in CHECK; y_in activity in DRIVE is ignored.
- X/Z on y_in is a bench concern. The RTL compares with ==, and the bench checks outputs with !==.

Test Plan:
- Good gate, SETTLE_CYCLES=1, LOOPS=1: pulse start → a/b sequence 00,01,10,11 each held 2 cycles; done at cycle 8; pass=1, err_count=0, fail_valid=0.
- Stuck-at-1 y_in, STOP_ON_ERR=1: start → stops after the first CHECK; done at cycle 2; err_count=1, fail_vec=00, fail_y=1, pass=0.
- Gate model acting as OR, STOP_ON_ERR=0, LOOPS=3: start → runs all 12 vectors; err_count=6, fail_vec=01, fail_y=1, pass=0, done at cycle 24.
- Stuck-at-0 y_in, ERR_W=2, LOOPS=4, STOP_ON_ERR=0 → 4 raw mismatches; err_count saturates at 3.
- abort asserted during the 3rd vector's DRIVE → next cycle busy=0, a_out=b_out=0, no done pulse; a subsequent start runs cleanly to pass=1.
- start re-pulsed mid-run is ignored (done timing unchanged). start+abort in the same IDLE cycle leaves busy=0. rst_n asserted mid-CHECK clears all outputs asynchronously, before the next clk edge.
